// File: rtl/wb_write_arbiter.sv
// Purpose : merges pipeline writeback (A) and buffered long-latency results (B) onto one regfile write port.
// Latency : A is combinational (zero cycles); B is written no earlier than the cycle after it is accepted.
// Backpress: b_ready_o drops while the B FIFO is full; A is never held off, but a starved B head raises stall_o.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   a_wen_i/a_wa_i/a_wd_i       pipeline writeback (always has priority)
//   b_valid_i/b_wa_i/b_wd_i     long-latency result, b_ready_o handshake
//   wen_o/wa_o/wd_o             register file write port
//   pending_mask_o              one bit per register with a live buffered write
//   fifo_count_o                occupied FIFO slots, killed entries included
//   stall_o                     request for a pipeline bubble so the FIFO head can drain
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     a_wen_i,
  input  logic [4:0]               a_wa_i,
  input  logic [31:0]              a_wd_i,
  input  logic                     b_valid_i,
  input  logic [4:0]               b_wa_i,
  input  logic [31:0]              b_wd_i,
  output logic                     b_ready_o,
  output logic                     wen_o,
  output logic [4:0]               wa_o,
  output logic [31:0]              wd_o,
  output logic [31:0]              pending_mask_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     stall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       wa_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [3:0]       starve_q, starve_d;
  logic             stall_q, stall_d;

  logic a_take;     // A owns the port this cycle
  logic empty;
  logic full;
  logic head_live;
  logic b_take;     // live head written this cycle
  logic pop;        // head leaves the FIFO (written or discarded as killed)
  logic push;       // B handshake completes
  logic store;      // accepted result actually occupies a slot

  // Gating A with reset keeps the write port quiet while reset is held.
  assign a_take    = rst_ni && a_wen_i && (a_wa_i != 5'd0);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head_live = !empty && live_q[head_q];
  assign b_take    = head_live && !a_take;
  // A killed head frees its slot regardless of A's activity.
  assign pop       = !empty && (!live_q[head_q] || !a_take);
  assign push      = b_valid_i && !full;
  assign store     = push && (b_wa_i != 5'd0);

  assign b_ready_o      = !full;
  assign fifo_count_o   = count_q;
  assign stall_o        = stall_q;

  // Write port mux
  always_comb begin
    wen_o = 1'b0;
    wa_o  = 5'd0;
    wd_o  = 32'd0;
    if (a_take) begin
      wen_o = 1'b1;
      wa_o  = a_wa_i;
      wd_o  = a_wd_i;
    end else if (b_take) begin
      wen_o = 1'b1;
      wa_o  = wa_q[head_q];
      wd_o  = wd_q[head_q];
    end
  end

  // Pending mask from registered state only; r0 never reported.
  always_comb begin
    pending_mask_o = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask_o[wa_q[i]] = 1'b1;
    end
    pending_mask_o[0] = 1'b0;
  end

  // Next-state: pointers, count, live bits, starvation tracking
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    live_d   = live_q;
    starve_d = starve_q;

    if (pop)   head_d = head_q + PW'(1);
    if (store) tail_d = tail_q + PW'(1);

    case ({store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) live_d[head_q] = 1'b0;

    // An A write supersedes every older buffered write to the same register.
    for (int i = 0; i < DEPTH; i++) begin
      if (a_take && (wa_q[i] == a_wa_i)) live_d[i] = 1'b0;
    end

    // B counts as older than a same-cycle A write, so it lands pre-killed.
    if (store) live_d[tail_q] = !(a_take && (b_wa_i == a_wa_i));

    if (empty || pop) begin
      starve_d = 4'd0;
    end else if (head_live && a_take && (starve_q != 4'(STARVE_LIMIT))) begin
      starve_d = starve_q + 4'd1;
    end

    // Counter clears whenever the head drains, so this also drops stall then.
    stall_d = (starve_d == 4'(STARVE_LIMIT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      live_q   <= '0;
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      live_q   <= live_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage needs no reset: it is only observed through live bits.
  always_ff @(posedge clk_i) begin
    if (store) begin
      wa_q[tail_q] <= b_wa_i;
      wd_q[tail_q] <= b_wd_i;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_wen = 1'b0;
  logic [4:0]    a_wa = 5'd0;
  logic [31:0]   a_wd = 32'd0;
  logic          b_valid = 1'b0;
  logic [4:0]    b_wa = 5'd0;
  logic [31:0]   b_wd = 32'd0;
  logic          b_ready;
  logic          wen;
  logic [4:0]    wa;
  logic [31:0]   wd;
  logic [31:0]   pending_mask;
  logic [CW-1:0] fifo_count;
  logic          stall;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .a_wen_i        (a_wen),
    .a_wa_i         (a_wa),
    .a_wd_i         (a_wd),
    .b_valid_i      (b_valid),
    .b_wa_i         (b_wa),
    .b_wd_i         (b_wd),
    .b_ready_o      (b_ready),
    .wen_o          (wen),
    .wa_o           (wa),
    .wd_o           (wd),
    .pending_mask_o (pending_mask),
    .fifo_count_o   (fifo_count),
    .stall_o        (stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the buffered B results as an ordered list.
  typedef struct {
    logic        live;
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t mq[$];
  int   m_starve = 0;
  bit   m_stall  = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_stall  = 1'b0;
  endtask

  // Apply the effect of one posedge with the inputs currently driven.
  task automatic model_edge();
    bit   at;
    bit   rdy;
    bit   emp;
    bit   drained;
    ent_t e;
    at      = a_wen && (a_wa != 5'd0);
    rdy     = (mq.size() != DEPTH);
    emp     = (mq.size() == 0);
    drained = !emp && (!mq[0].live || !at);
    if (emp || drained) begin
      m_starve = 0;
      m_stall  = 1'b0;
    end else if (mq[0].live && at) begin
      if (m_starve < LIMIT) m_starve++;
      if (m_starve == LIMIT) m_stall = 1'b1;
    end
    if (drained) void'(mq.pop_front());
    for (int k = 0; k < mq.size(); k++) begin
      if (at && mq[k].wa == a_wa) mq[k].live = 1'b0;
    end
    if (b_valid && rdy && b_wa != 5'd0) begin
      e.live = !(at && b_wa == a_wa);
      e.wa   = b_wa;
      e.wd   = b_wd;
      mq.push_back(e);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, logic ewen, logic [4:0] ewa, logic [31:0] ewd,
                           logic erdy, logic [CW-1:0] ecnt, logic [31:0] emask, logic estall);
    chk({tag, ".wen"},   32'(wen),          32'(ewen));
    chk({tag, ".wa"},    32'(wa),           32'(ewa));
    chk({tag, ".wd"},    wd,                ewd);
    chk({tag, ".rdy"},   32'(b_ready),      32'(erdy));
    chk({tag, ".cnt"},   32'(fifo_count),   32'(ecnt));
    chk({tag, ".mask"},  pending_mask,      emask);
    chk({tag, ".stall"}, 32'(stall),        32'(estall));
  endtask

  task automatic check_model(string tag);
    logic        ewen;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [31:0] emask;
    ewen = 1'b0; ewa = 5'd0; ewd = 32'd0; emask = 32'd0;
    if (a_wen && a_wa != 5'd0) begin
      ewen = 1'b1; ewa = a_wa; ewd = a_wd;
    end else if (mq.size() > 0 && mq[0].live) begin
      ewen = 1'b1; ewa = mq[0].wa; ewd = mq[0].wd;
    end
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k].live) emask = emask | (32'd1 << mq[k].wa);
    end
    check_all(tag, ewen, ewa, ewd, 1'(mq.size() != DEPTH), CW'(mq.size()), emask, m_stall);
  endtask

  // Drive inputs just after the falling edge; outputs settle by +1.
  task automatic drive(logic aw, logic [4:0] awa, logic [31:0] awd,
                       logic bv, logic [4:0] bwa, logic [31:0] bwd);
    @(negedge clk);
    a_wen = aw; a_wa = awa; a_wd = awd;
    b_valid = bv; b_wa = bwa; b_wd = bwd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
  endtask

  typedef struct {
    logic          aw;
    logic [4:0]    awa;
    logic [31:0]   awd;
    logic          bv;
    logic [4:0]    bwa;
    logic [31:0]   bwd;
    logic          ewen;
    logic [4:0]    ewa;
    logic [31:0]   ewd;
    logic [CW-1:0] ecnt;
    logic [31:0]   emask;
  } vec_t;

  vec_t vt[12];

  initial begin
    // Directed sequence from an empty FIFO; each row is one cycle.
    //            aw  awa    awd     bv  bwa     bwd     ewen ewa    ewd     cnt  mask
    vt[0]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  0, 32'h0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hA5, 1'b0, 5'd0,  32'h0,  0, 32'h0};
    vt[2]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hA5, 1, 32'h20};
    vt[3]  = '{1'b1, 5'd9,  32'h2,  1'b1, 5'd9,  32'h1,  1'b1, 5'd9,  32'h2,  0, 32'h0};
    vt[4]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1, 32'h0};
    vt[5]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd0,  32'h55, 1'b0, 5'd0,  32'h0,  0, 32'h0};
    vt[6]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd12, 32'h77, 1'b0, 5'd0,  32'h0,  0, 32'h0};
    vt[7]  = '{1'b1, 5'd0,  32'hFF, 1'b0, 5'd0,  32'h0,  1'b1, 5'd12, 32'h77, 1, 32'h1000};
    vt[8]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd6,  32'h11, 1'b0, 5'd0,  32'h0,  0, 32'h0};
    vt[9]  = '{1'b1, 5'd6,  32'h22, 1'b0, 5'd0,  32'h0,  1'b1, 5'd6,  32'h22, 1, 32'h40};
    vt[10] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1, 32'h0};
    vt[11] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  0, 32'h0};

    // Reset held: A activity must not reach the write port.
    a_wen = 1'b1; a_wa = 5'd5; a_wd = 32'hDEAD;
    #2;
    check_all("reset", 1'b0, 5'd0, 32'd0, 1'b1, '0, 32'd0, 1'b0);
    a_wen = 1'b0; a_wa = 5'd0; a_wd = 32'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].aw, vt[i].awa, vt[i].awd, vt[i].bv, vt[i].bwa, vt[i].bwd);
      check_all($sformatf("vec%0d", i), vt[i].ewen, vt[i].ewa, vt[i].ewd,
                1'b1, vt[i].ecnt, vt[i].emask, 1'b0);
      tick();
    end

    // Starvation: A writes r3 every cycle while B fills the FIFO.
    drive(1, 3, 32'h33, 1, 7,  32'h70); check_all("stv0", 1, 3, 32'h33, 1, 0, 32'h0,   0); tick();
    drive(1, 3, 32'h33, 1, 8,  32'h80); check_all("stv1", 1, 3, 32'h33, 1, 1, 32'h80,  0); tick();
    drive(1, 3, 32'h33, 1, 9,  32'h90); check_all("stv2", 1, 3, 32'h33, 1, 2, 32'h180, 0); tick();
    drive(1, 3, 32'h33, 1, 10, 32'hA0); check_all("stv3", 1, 3, 32'h33, 1, 3, 32'h380, 0); tick();
    drive(1, 3, 32'h33, 1, 11, 32'hB0); check_all("stv4", 1, 3, 32'h33, 0, 4, 32'h780, 0); tick();
    drive(1, 3, 32'h33, 0, 0,  32'h0);  check_all("stv5", 1, 3, 32'h33, 0, 4, 32'h780, 1); tick();
    drive(0, 0, 32'h0,  0, 0,  32'h0);  check_all("stv6", 1, 7, 32'h70, 0, 4, 32'h780, 1); tick();
    drive(0, 0, 32'h0,  0, 0,  32'h0);  check_all("stv7", 1, 8, 32'h80, 1, 3, 32'h700, 0); tick();
    drive(0, 0, 32'h0,  0, 0,  32'h0);  check_all("stv8", 1, 9, 32'h90, 1, 2, 32'h600, 0); tick();
    drive(0, 0, 32'h0,  0, 0,  32'h0);  check_all("stv9", 1, 10, 32'hA0, 1, 1, 32'h400, 0); tick();
    drive(0, 0, 32'h0,  0, 0,  32'h0);  check_all("stv10", 0, 0, 32'h0, 1, 0, 32'h0,  0); tick();

    // Reset mid-operation with three entries queued behind busy A.
    drive(1, 3, 32'h33, 1, 1, 32'h10); tick();
    drive(1, 3, 32'h33, 1, 2, 32'h20); tick();
    drive(1, 3, 32'h33, 1, 4, 32'h40); tick();
    drive(1, 3, 32'h33, 0, 0, 32'h0);
    check_all("pre_rst", 1, 3, 32'h33, 1, 3, 32'h16, 0);
    #1 rst_n = 1'b0;
    #1 check_all("mid_rst", 0, 0, 32'h0, 1, 0, 32'h0, 0);
    model_reset();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0); check_all("post_rst0", 0, 0, 32'h0, 1, 0, 32'h0, 0); tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0); check_all("post_rst1", 0, 0, 32'h0, 1, 0, 32'h0, 0); tick();

    // Randomized traffic against the model; A density varies by phase.
    for (int i = 0; i < 900; i++) begin
      int pct;
      logic aw;
      logic bv;
      case ((i / 100) % 3)
        0:       pct = 30;
        1:       pct = 90;
        default: pct = 60;
      endcase
      aw = ($urandom_range(0, 99) < pct);
      bv = ($urandom_range(0, 99) < 55);
      drive(aw, 5'($urandom_range(0, 7)), $urandom,
            bv, 5'($urandom_range(0, 7)), $urandom);
      check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
